// File: rtl/alu_pkg.sv
// Shared types for the ALU command issuer: opcodes, issuer FSM states and datapath widths.
package alu_pkg;

  localparam int OPERAND_W = 8;
  localparam int RESULT_W  = 16;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_AND = 3'b010,
    OP_XOR = 3'b011
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } issuer_state_e;

endpackage

// File: rtl/alu_timeout_cnt.sv
// Cycle counter for the WAIT state; o_terminal flags the last cycle before a missing done is declared.
module alu_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  logic [7:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_terminal = (r_count == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues one command at a time to the single-cycle ALU as a start pulse and returns its result
// (or a timeout error) on a valid/ready response port.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [OPERAND_W-1:0] i_cmd_a,
  input  logic [OPERAND_W-1:0] i_cmd_b,
  input  logic [2:0]           i_cmd_op,
  output logic                 o_alu_start,
  output logic [OPERAND_W-1:0] o_alu_a,
  output logic [OPERAND_W-1:0] o_alu_b,
  output logic [2:0]           o_alu_op,
  input  logic                 i_alu_done,
  input  logic [RESULT_W-1:0]  i_alu_result,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [RESULT_W-1:0]  o_rsp_result,
  output logic [2:0]           o_rsp_op,
  output logic                 o_rsp_err,
  output logic [15:0]          o_cmd_count
);

  issuer_state_e        r_state;
  logic                 r_cmd_ready;
  logic                 r_alu_start;
  logic [OPERAND_W-1:0] r_alu_a;
  logic [OPERAND_W-1:0] r_alu_b;
  logic [2:0]           r_alu_op;
  logic                 r_rsp_valid;
  logic [RESULT_W-1:0]  r_rsp_result;
  logic [2:0]           r_rsp_op;
  logic                 r_rsp_err;
  logic [15:0]          r_cmd_count;

  logic w_cnt_clear;
  logic w_cnt_enable;
  logic w_timeout;

  assign w_cnt_clear  = (r_state == ST_ISSUE);
  assign w_cnt_enable = (r_state == ST_WAIT) && !i_alu_done && !w_timeout;

  alu_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_cnt_clear),
    .i_enable  (w_cnt_enable),
    .o_terminal(w_timeout)
  );

  // The ALU operand registers double as the command latches; NOP never touches them
  // because the ALU would not answer it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cmd_ready  <= 1'b1;
      r_alu_start  <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_op     <= '0;
      r_rsp_err    <= 1'b0;
      r_cmd_count  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            if (i_cmd_op == OP_NOP) begin
              r_rsp_valid  <= 1'b1;
              r_rsp_result <= '0;
              r_rsp_err    <= 1'b0;
              r_rsp_op     <= i_cmd_op;
              r_state      <= ST_RESP;
            end else begin
              r_alu_start <= 1'b1;
              r_alu_a     <= i_cmd_a;
              r_alu_b     <= i_cmd_b;
              r_alu_op    <= i_cmd_op;
              r_state     <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          r_alu_start <= 1'b0;
          r_state     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_alu_done) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_result <= i_alu_result;
            r_rsp_err    <= 1'b0;
            r_rsp_op     <= r_alu_op;
            r_state      <= ST_RESP;
          end else if (w_timeout) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_result <= '0;
            r_rsp_err    <= 1'b1;
            r_rsp_op     <= r_alu_op;
            r_state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_cmd_count <= r_cmd_count + 16'd1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_cmd_ready  = r_cmd_ready;
  assign o_alu_start  = r_alu_start;
  assign o_alu_a      = r_alu_a;
  assign o_alu_b      = r_alu_b;
  assign o_alu_op     = r_alu_op;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_op     = r_rsp_op;
  assign o_rsp_err    = r_rsp_err;
  assign o_cmd_count  = r_cmd_count;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a one-cycle-latency ALU model that can be muted to force timeouts.
module tb_alu_cmd_issuer;

  logic        clk;
  logic        rstN;
  logic        cmdValid;
  logic        cmdReady;
  logic [7:0]  cmdA;
  logic [7:0]  cmdB;
  logic [2:0]  cmdOp;
  logic        aluStart;
  logic [7:0]  aluA;
  logic [7:0]  aluB;
  logic [2:0]  aluOp;
  logic        aluDone;
  logic [15:0] aluResult;
  logic        rspValid;
  logic        rspReady;
  logic [15:0] rspResult;
  logic [2:0]  rspOp;
  logic        rspErr;
  logic [15:0] cmdCount;

  logic        aluEnable;
  int          checks;
  int          errors;
  int          expCount;
  int          cycle;
  int          startCount;
  int          acceptCycle[$];
  logic [15:0] rspLog[$];

  alu_cmd_issuer #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rstN),
    .i_cmd_valid (cmdValid),
    .o_cmd_ready (cmdReady),
    .i_cmd_a     (cmdA),
    .i_cmd_b     (cmdB),
    .i_cmd_op    (cmdOp),
    .o_alu_start (aluStart),
    .o_alu_a     (aluA),
    .o_alu_b     (aluB),
    .o_alu_op    (aluOp),
    .i_alu_done  (aluDone),
    .i_alu_result(aluResult),
    .o_rsp_valid (rspValid),
    .i_rsp_ready (rspReady),
    .o_rsp_result(rspResult),
    .o_rsp_op    (rspOp),
    .o_rsp_err   (rspErr),
    .o_cmd_count (cmdCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ALU model: registers done and result one edge after start; reserved ops answer 0.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      aluDone   <= 1'b0;
      aluResult <= '0;
    end else begin
      aluDone <= aluStart && aluEnable;
      case (aluOp)
        3'b001:  aluResult <= {8'h00, aluA} + {8'h00, aluB};
        3'b010:  aluResult <= {8'h00, aluA & aluB};
        3'b011:  aluResult <= {8'h00, aluA ^ aluB};
        default: aluResult <= 16'h0000;
      endcase
    end
  end

  always @(posedge clk) begin
    cycle++;
    if (rstN) begin
      if (cmdValid && cmdReady) acceptCycle.push_back(cycle);
      if (rspValid && rspReady) rspLog.push_back(rspResult);
      if (aluStart) startCount++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic waitRsp(input int maxCycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxCycles; i++) begin
      @(negedge clk);
      if (rspValid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    @(negedge clk);
    cmdA     = a;
    cmdB     = b;
    cmdOp    = op;
    cmdValid = 1'b1;
    @(negedge clk);
    cmdValid = 1'b0;
  endtask

  task automatic handshake();
    rspReady = 1'b1;
    @(negedge clk);
    rspReady = 1'b0;
    expCount++;
  endtask

  task automatic test_reset();
    rstN = 1'b0; cmdValid = 1'b0; cmdA = '0; cmdB = '0; cmdOp = '0;
    rspReady = 1'b0; aluEnable = 1'b1; expCount = 0;
    #12;
    checks++; if (cmdReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_cmd_ready got %b want 1", cmdReady); end
    checks++; if (aluStart !== 1'b0) begin errors++; $display("[TB] FAIL reset_alu_start got %b want 0", aluStart); end
    checks++; if (rspValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid got %b want 0", rspValid); end
    checks++; if (cmdCount !== 16'h0) begin errors++; $display("[TB] FAIL reset_cmd_count got %h want 0000", cmdCount); end
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic test_add();
    int s0;
    s0 = startCount;
    drive(8'hC8, 8'h64, 3'b001);
    checks++; if (aluStart !== 1'b1) begin errors++; $display("[TB] FAIL add_start got %b want 1", aluStart); end
    checks++; if ({aluA, aluB, aluOp} !== {8'hC8, 8'h64, 3'b001}) begin errors++; $display("[TB] FAIL add_alu_operands got %h/%h/%b want c8/64/001", aluA, aluB, aluOp); end
    @(negedge clk);
    checks++; if (rspValid !== 1'b0) begin errors++; $display("[TB] FAIL add_rsp_early got %b want 0", rspValid); end
    @(negedge clk);
    checks++; if (rspValid !== 1'b1) begin errors++; $display("[TB] FAIL add_rsp_latency got %b want 1", rspValid); end
    checks++; if (rspResult !== 16'h012C) begin errors++; $display("[TB] FAIL add_result got %h want 012c", rspResult); end
    checks++; if (rspErr !== 1'b0 || rspOp !== 3'b001) begin errors++; $display("[TB] FAIL add_err_op got %b/%b want 0/001", rspErr, rspOp); end
    checks++; if (startCount - s0 != 1) begin errors++; $display("[TB] FAIL add_start_pulses got %0d want 1", startCount - s0); end
    handshake();
    checks++; if (cmdCount !== 16'd1) begin errors++; $display("[TB] FAIL add_cmd_count got %0d want 1", cmdCount); end
    checks++; if (rspValid !== 1'b0 || cmdReady !== 1'b1) begin errors++; $display("[TB] FAIL add_return_idle got valid=%b ready=%b want 0/1", rspValid, cmdReady); end
  endtask

  task automatic test_back_to_back();
    int n0;
    int r0;
    int guard;
    n0 = acceptCycle.size();
    r0 = rspLog.size();
    rspReady = 1'b1;
    @(negedge clk);
    cmdA = 8'hF0; cmdB = 8'h3C; cmdOp = 3'b010; cmdValid = 1'b1;
    guard = 0;
    while (acceptCycle.size() < n0 + 1 && guard < 10) begin @(negedge clk); guard++; end
    cmdA = 8'hFF; cmdB = 8'h0F; cmdOp = 3'b011;
    guard = 0;
    while (acceptCycle.size() < n0 + 2 && guard < 10) begin @(negedge clk); guard++; end
    cmdValid = 1'b0;
    guard = 0;
    while (rspLog.size() < r0 + 2 && guard < 20) begin @(negedge clk); guard++; end
    rspReady = 1'b0;
    checks++;
    if (acceptCycle.size() < n0 + 2 || rspLog.size() < r0 + 2) begin
      errors++;
      $display("[TB] FAIL b2b_timeout got accepts=%0d responses=%0d want 2/2", acceptCycle.size() - n0, rspLog.size() - r0);
    end else begin
      expCount += 2;
      if (rspLog[r0] !== 16'h0030) begin errors++; $display("[TB] FAIL b2b_and_result got %h want 0030", rspLog[r0]); end
      checks++; if (rspLog[r0+1] !== 16'h00F0) begin errors++; $display("[TB] FAIL b2b_xor_result got %h want 00f0", rspLog[r0+1]); end
      checks++; if (acceptCycle[n0+1] - acceptCycle[n0] != 4) begin errors++; $display("[TB] FAIL b2b_spacing got %0d want 4", acceptCycle[n0+1] - acceptCycle[n0]); end
      checks++; if (cmdCount !== 16'(expCount)) begin errors++; $display("[TB] FAIL b2b_cmd_count got %0d want %0d", cmdCount, expCount); end
    end
  endtask

  task automatic test_nop();
    int s0;
    s0 = startCount;
    drive(8'h05, 8'h07, 3'b000);
    checks++; if (rspValid !== 1'b1) begin errors++; $display("[TB] FAIL nop_latency got %b want 1", rspValid); end
    checks++; if (rspResult !== 16'h0 || rspErr !== 1'b0 || rspOp !== 3'b000) begin errors++; $display("[TB] FAIL nop_fields got %h/%b/%b want 0000/0/000", rspResult, rspErr, rspOp); end
    checks++; if (startCount != s0 || aluStart !== 1'b0) begin errors++; $display("[TB] FAIL nop_no_start got %0d pulses want 0", startCount - s0); end
    handshake();
  endtask

  task automatic test_reserved();
    int s0;
    bit ok;
    s0 = startCount;
    drive(8'h03, 8'h04, 3'b101);
    waitRsp(6, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL rsv_timeout got no response want rsp_valid"); end
    checks++; if (rspResult !== 16'h0 || rspErr !== 1'b0 || rspOp !== 3'b101) begin errors++; $display("[TB] FAIL rsv_fields got %h/%b/%b want 0000/0/101", rspResult, rspErr, rspOp); end
    checks++; if (startCount - s0 != 1) begin errors++; $display("[TB] FAIL rsv_start_pulses got %0d want 1", startCount - s0); end
    handshake();
  endtask

  task automatic test_timeout();
    bit ok;
    aluEnable = 1'b0;
    drive(8'h01, 8'h01, 3'b001);
    checks++; if (aluStart !== 1'b1) begin errors++; $display("[TB] FAIL to_issue got %b want 1", aluStart); end
    repeat (4) @(negedge clk);
    checks++; if (rspValid !== 1'b0) begin errors++; $display("[TB] FAIL to_early got %b want 0", rspValid); end
    @(negedge clk);
    checks++; if (rspValid !== 1'b1) begin errors++; $display("[TB] FAIL to_latency got %b want 1", rspValid); end
    checks++; if (rspErr !== 1'b1 || rspResult !== 16'h0) begin errors++; $display("[TB] FAIL to_fields got err=%b res=%h want 1/0000", rspErr, rspResult); end
    aluEnable = 1'b1;
    handshake();
    drive(8'h10, 8'h20, 3'b001);
    waitRsp(6, ok);
    checks++; if (!ok || rspResult !== 16'h0030 || rspErr !== 1'b0) begin errors++; $display("[TB] FAIL to_recover got ok=%b res=%h err=%b want 1/0030/0", ok, rspResult, rspErr); end
    handshake();
  endtask

  task automatic test_stall();
    bit ok;
    int bad;
    drive(8'hAA, 8'h55, 3'b011);
    waitRsp(6, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL stall_no_rsp got no response want rsp_valid"); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (rspValid !== 1'b1 || rspResult !== 16'h00FF || cmdReady !== 1'b0 || cmdCount !== 16'(expCount)) begin
        errors++;
        $display("[TB] FAIL stall_hold got valid=%b res=%h ready=%b count=%0d want 1/00ff/0/%0d", rspValid, rspResult, cmdReady, cmdCount, expCount);
      end
    end
    handshake();
    checks++; if (cmdCount !== 16'(expCount)) begin errors++; $display("[TB] FAIL stall_count got %0d want %0d", cmdCount, expCount); end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    aluEnable = 1'b0;
    drive(8'h09, 8'h09, 3'b001);
    @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    checks++; if (cmdReady !== 1'b1 || aluStart !== 1'b0) begin errors++; $display("[TB] FAIL rst_ctrl got ready=%b start=%b want 1/0", cmdReady, aluStart); end
    checks++; if ({aluA, aluB, aluOp} !== 19'h0) begin errors++; $display("[TB] FAIL rst_alu got %h/%h/%b want 0", aluA, aluB, aluOp); end
    checks++; if (rspValid !== 1'b0 || rspResult !== 16'h0 || rspOp !== 3'b0 || rspErr !== 1'b0) begin errors++; $display("[TB] FAIL rst_rsp got %b/%h/%b/%b want 0", rspValid, rspResult, rspOp, rspErr); end
    checks++; if (cmdCount !== 16'h0) begin errors++; $display("[TB] FAIL rst_count got %0d want 0", cmdCount); end
    repeat (6) @(negedge clk);
    checks++; if (rspValid !== 1'b0) begin errors++; $display("[TB] FAIL rst_no_rsp got %b want 0", rspValid); end
    rstN = 1'b1;
    aluEnable = 1'b1;
    expCount = 0;
    drive(8'h03, 8'h04, 3'b001);
    waitRsp(6, ok);
    checks++; if (!ok || rspResult !== 16'h0007) begin errors++; $display("[TB] FAIL rst_recover got ok=%b res=%h want 1/0007", ok, rspResult); end
    handshake();
    checks++; if (cmdCount !== 16'd1) begin errors++; $display("[TB] FAIL rst_recover_count got %0d want 1", cmdCount); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cycle = 0;
    startCount = 0;
    test_reset();
    test_add();
    test_back_to_back();
    test_nop();
    test_reserved();
    test_timeout();
    test_stall();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
